// File: rtl/n100_irq_sync_if.sv
// n100_irq_sync_if: interrupt/event lines, core handshakes and synchronized results.
`default_nettype none

interface n100_irq_sync_if #(
  parameter int CNT_W = 8
);
  logic             dbg_irq_a;
  logic             nmi_a;
  logic             tmr_irq_a;
  logic             sft_irq_a;
  logic             ext_irq_a;
  logic             rx_evt_a;
  logic             dbg_ack;
  logic             nmi_ack;
  logic             core_wfi;
  logic [2:0]       mie_mask;
  logic             tmr_irq;
  logic             sft_irq;
  logic             ext_irq;
  logic             dbg_pend;
  logic             nmi_pend;
  logic             rx_evt_pend;
  logic             wfi_wake;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output dbg_irq_a, nmi_a, tmr_irq_a, sft_irq_a, ext_irq_a, rx_evt_a,
    output dbg_ack, nmi_ack, core_wfi, mie_mask,
    input  tmr_irq, sft_irq, ext_irq, dbg_pend, nmi_pend, rx_evt_pend,
    input  wfi_wake, evt_cnt
  );

  modport slave (
    input  dbg_irq_a, nmi_a, tmr_irq_a, sft_irq_a, ext_irq_a, rx_evt_a,
    input  dbg_ack, nmi_ack, core_wfi, mie_mask,
    output tmr_irq, sft_irq, ext_irq, dbg_pend, nmi_pend, rx_evt_pend,
    output wfi_wake, evt_cnt
  );
endinterface

`default_nettype wire

// File: rtl/n100_irq_sync.sv
//==============================================================================
// Module      : n100_irq_sync
// Description : Interrupt synchronizer, edge latch, event counter and WFI wake
//               FSM. Define N100_IRQ_SYNC_2FF_EN for a two-flop synchronizer.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module n100_irq_sync #(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  n100_irq_sync_if.slave  bus
);

`ifdef N100_IRQ_SYNC_2FF_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif
  localparam logic [1:0] WARM_MAX = 2'(SYNC_DEPTH + 1);

  localparam int IDX_DBG = 0;
  localparam int IDX_NMI = 1;
  localparam int IDX_TMR = 2;
  localparam int IDX_SFT = 3;
  localparam int IDX_EXT = 4;
  localparam int IDX_RX  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

  logic [5:0]       w_async;
  logic [5:0]       r_sync [SYNC_DEPTH];
  logic [5:0]       w_lvl;
  logic [2:0]       r_hist;
  logic [1:0]       r_warm;
  logic             w_warm_done;
  logic             w_dbg_edge;
  logic             w_nmi_edge;
  logic             w_rx_edge;
  logic             r_dbg_pend;
  logic             r_nmi_pend;
  logic             r_rx_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_sum;
  logic [1:0]       w_cnt_inc;
  state_t           r_state;
  state_t           w_next_state;
  logic             r_wfi_block;
  logic [2:0]       w_irq_lvl;
  logic             w_wake_cond;

  assign w_async = {bus.rx_evt_a, bus.ext_irq_a, bus.sft_irq_a,
                    bus.tmr_irq_a, bus.nmi_a, bus.dbg_irq_a};

  for (genvar g = 0; g < SYNC_DEPTH; g++) begin : g_sync_stage
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync[g] <= '0;
        else        r_sync[g] <= w_async;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync[g] <= '0;
        else        r_sync[g] <= r_sync[g-1];
      end
    end
  end

  assign w_lvl = r_sync[SYNC_DEPTH-1];

  // Edges are suppressed until the history flop holds a real post-reset
  // sample, so a line already high at release is never reported as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_warm <= '0;
    end else begin
      r_hist <= {w_lvl[IDX_RX], w_lvl[IDX_NMI], w_lvl[IDX_DBG]};
      if (!w_warm_done) r_warm <= r_warm + 2'd1;
    end
  end

  assign w_warm_done = (r_warm == WARM_MAX);
  assign w_dbg_edge  = w_warm_done & w_lvl[IDX_DBG] & ~r_hist[0];
  assign w_nmi_edge  = w_warm_done & w_lvl[IDX_NMI] & ~r_hist[1];
  assign w_rx_edge   = w_warm_done & w_lvl[IDX_RX]  & ~r_hist[2];

  assign w_cnt_inc = {1'b0, w_nmi_edge} + {1'b0, w_dbg_edge};
  assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_cnt_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg_pend <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_rx_pend  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_dbg_edge)       r_dbg_pend <= 1'b1;
      else if (bus.dbg_ack) r_dbg_pend <= 1'b0;
      if (w_nmi_edge)       r_nmi_pend <= 1'b1;
      else if (bus.nmi_ack) r_nmi_pend <= 1'b0;
      if (w_rx_edge)              r_rx_pend <= 1'b1;
      else if (r_state == ST_WAKE) r_rx_pend <= 1'b0;
      if (w_cnt_sum[CNT_W]) r_cnt <= '1;
      else                  r_cnt <= w_cnt_sum[CNT_W-1:0];
    end
  end

  // mie_mask is {meie, mtie, msie}
  assign w_irq_lvl   = {w_lvl[IDX_EXT], w_lvl[IDX_TMR], w_lvl[IDX_SFT]};
  assign w_wake_cond = r_nmi_pend | r_dbg_pend | r_rx_pend |
                       (|(w_irq_lvl & bus.mie_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wfi_block <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_WAKE) r_wfi_block <= 1'b1;
      else if (!bus.core_wfi) r_wfi_block <= 1'b0;
    end
  end

  // A WAKE blocks re-entry to SLEEP until core_wfi has been seen low.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.core_wfi && !r_wfi_block) w_next_state = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (w_wake_cond)        w_next_state = ST_WAKE;
        else if (!bus.core_wfi) w_next_state = ST_IDLE;
      end
      ST_WAKE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign bus.tmr_irq     = w_lvl[IDX_TMR];
  assign bus.sft_irq     = w_lvl[IDX_SFT];
  assign bus.ext_irq     = w_lvl[IDX_EXT];
  assign bus.dbg_pend    = r_dbg_pend;
  assign bus.nmi_pend    = r_nmi_pend;
  assign bus.rx_evt_pend = r_rx_pend;
  assign bus.wfi_wake    = (r_state == ST_WAKE);
  assign bus.evt_cnt     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_n100_irq_sync.sv
// tb_n100_irq_sync: randomized and directed checks of n100_irq_sync against a cycle model.
`default_nettype none

module tb_n100_irq_sync;
  localparam int CNT_W = 8;
`ifdef N100_IRQ_SYNC_2FF_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  n100_irq_sync_if #(.CNT_W(CNT_W)) bus();
  n100_irq_sync #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // Sampled input vector bit order: 0 dbg, 1 nmi, 2 tmr, 3 sft, 4 ext, 5 rx.
  typedef struct packed {
    logic [5:0]       h0, h1, h2;   // h0 = most recent sample
    logic [2:0]       ns;           // samples since reset, saturating at 4
    logic [2:0]       lvl;          // {tmr, sft, ext}
    logic             dbg, nmi, rx;
    logic [1:0]       st;           // 0 idle, 1 sleep, 2 wake
    logic             blk;
    logic [CNT_W-1:0] cnt;
  } model_t;

  model_t m;

  function automatic model_t step(model_t p, logic [5:0] cur, logic nack, logic dack,
                                  logic wfi, logic [2:0] mie);
    model_t r;
    logic [5:0] lv, a, b;
    logic rise_ok, rd, rn, rr, wake;
    int sum;
    r = p;
    if (D == 1) lv = cur; else lv = (p.ns >= 3'd1) ? p.h0 : 6'd0;
    a = (D == 1) ? p.h0 : p.h1;      // input sample D edges ago
    b = (D == 1) ? p.h1 : p.h2;      // the one before it
    rise_ok = (p.ns >= 3'(D + 1));
    rd = rise_ok & a[0] & ~b[0];
    rn = rise_ok & a[1] & ~b[1];
    rr = rise_ok & a[5] & ~b[5];
    wake = p.nmi | p.dbg | p.rx | (p.lvl[2] & mie[1]) | (p.lvl[1] & mie[0]) | (p.lvl[0] & mie[2]);
    r.dbg = rd ? 1'b1 : (dack ? 1'b0 : p.dbg);
    r.nmi = rn ? 1'b1 : (nack ? 1'b0 : p.nmi);
    r.rx  = rr ? 1'b1 : ((p.st == 2'd2) ? 1'b0 : p.rx);
    sum = int'(p.cnt) + int'(rd) + int'(rn);
    r.cnt = (sum > (2**CNT_W - 1)) ? {CNT_W{1'b1}} : CNT_W'(sum);
    case (p.st)
      2'd0:    r.st = (wfi && !p.blk) ? 2'd1 : 2'd0;
      2'd1:    r.st = wake ? 2'd2 : (!wfi ? 2'd0 : 2'd1);
      default: r.st = 2'd0;
    endcase
    if (p.st == 2'd2) r.blk = 1'b1; else if (!wfi) r.blk = 1'b0;
    r.lvl = {lv[2], lv[3], lv[4]};
    r.h2 = p.h1; r.h1 = p.h0; r.h0 = cur;
    r.ns = (p.ns < 3'd4) ? p.ns + 3'd1 : p.ns;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m, {bus.rx_evt_a, bus.ext_irq_a, bus.sft_irq_a, bus.tmr_irq_a,
                       bus.nmi_a, bus.dbg_irq_a},
                   bus.nmi_ack, bus.dbg_ack, bus.core_wfi, bus.mie_mask);
  end

  wire [CNT_W+6:0] dut_vec = {bus.tmr_irq, bus.sft_irq, bus.ext_irq, bus.dbg_pend,
                              bus.nmi_pend, bus.rx_evt_pend, bus.wfi_wake, bus.evt_cnt};
  wire [CNT_W+6:0] exp_vec = {m.lvl, m.dbg, m.nmi, m.rx, (m.st == 2'd2), m.cnt};

  task automatic clear_inputs();
    {bus.dbg_irq_a, bus.nmi_a, bus.tmr_irq_a, bus.sft_irq_a, bus.ext_irq_a, bus.rx_evt_a} = '0;
    {bus.dbg_ack, bus.nmi_ack, bus.core_wfi} = '0;
    bus.mie_mask = 3'b000;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.nmi_a = 1'b1; bus.tmr_irq_a = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", dut_vec); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL reset_release: got %h want 0", dut_vec); end
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL reset_lockstep: got %h want %h", dut_vec, exp_vec); end
    end
    checks++;
    if (bus.nmi_pend !== 1'b0 || bus.tmr_irq !== 1'b1)
      begin errors++; $display("FAIL reset_high_line: nmi_pend=%b tmr_irq=%b want 0 1", bus.nmi_pend, bus.tmr_irq); end
    clear_inputs();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nmi_latency();
    int lat;
    logic [CNT_W-1:0] base;
    base = m.cnt;
    bus.nmi_a = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (bus.nmi_pend === 1'b1) break;
    end
    checks++;
    if (lat !== D + 1) begin errors++; $display("FAIL nmi_latency: got %0d want %0d", lat, D + 1); end
    checks++;
    if (bus.evt_cnt !== base + 1'b1) begin errors++; $display("FAIL nmi_count: got %0d want %0d", bus.evt_cnt, base + 1'b1); end
    repeat (3) @(negedge clk);
    bus.nmi_ack = 1'b1;
    @(negedge clk);
    bus.nmi_ack = 1'b0;
    checks++;
    if (bus.nmi_pend !== 1'b0) begin errors++; $display("FAIL nmi_ack_clear: got %b want 0", bus.nmi_pend); end
    bus.nmi_ack = 1'b1;     // ack while clear must be harmless
    @(negedge clk);
    bus.nmi_ack = 1'b0;
    checks++;
    if (dut_vec !== exp_vec || bus.nmi_pend !== 1'b0)
      begin errors++; $display("FAIL nmi_idle_ack: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_ack_collision();
    logic [CNT_W-1:0] base;
    bus.nmi_a = 1'b0;
    repeat (3) @(negedge clk);
    bus.nmi_a = 1'b1;
    repeat (D + 2) @(negedge clk);
    bus.nmi_a = 1'b0;
    repeat (3) @(negedge clk);
    base = m.cnt;
    bus.nmi_a = 1'b1;
    repeat (D) @(negedge clk);
    bus.nmi_ack = 1'b1;
    @(negedge clk);
    bus.nmi_ack = 1'b0;
    checks++;
    if (bus.nmi_pend !== 1'b1) begin errors++; $display("FAIL collision_pend: got %b want 1", bus.nmi_pend); end
    checks++;
    if (bus.evt_cnt !== base + 1'b1) begin errors++; $display("FAIL collision_count: got %0d want %0d", bus.evt_cnt, base + 1'b1); end
    bus.nmi_ack = 1'b1;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_wfi_wake();
    int pulses;
    bus.mie_mask = 3'b010;
    bus.core_wfi = 1'b1;
    repeat (4) @(negedge clk);
    bus.tmr_irq_a = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      pulses += int'(bus.wfi_wake);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL wake_lockstep: got %h want %h", dut_vec, exp_vec); end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL wake_pulse_count: got %0d want 1", pulses); end
    bus.core_wfi = 1'b0;
    repeat (2) @(negedge clk);
    bus.mie_mask = 3'b000;
    bus.core_wfi = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(bus.wfi_wake);
    end
    checks++;
    if (pulses !== 0 || m.st !== 2'd1) begin errors++; $display("FAIL masked_no_wake: pulses=%0d want 0", pulses); end
  endtask

  task automatic test_rx_evt();
    int pulses;
    pulses = 0;
    bus.rx_evt_a = 1'b1;
    repeat (2) @(negedge clk);
    bus.rx_evt_a = 1'b0;
    repeat (15) begin
      @(negedge clk);
      pulses += int'(bus.wfi_wake);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL rx_lockstep: got %h want %h", dut_vec, exp_vec); end
    end
    checks++;
    if (pulses !== 1 || bus.rx_evt_pend !== 1'b0)
      begin errors++; $display("FAIL rx_wake: pulses=%0d pend=%b want 1 0", pulses, bus.rx_evt_pend); end
    clear_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      bus.dbg_irq_a = 1'b1;
      @(negedge clk);
      bus.dbg_irq_a = 1'b0;
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL sat_lockstep: got %h want %h", dut_vec, exp_vec); end
    end
    repeat (D + 2) @(negedge clk);
    checks++;
    if (bus.evt_cnt !== 8'd255) begin errors++; $display("FAIL saturate: got %0d want 255", bus.evt_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] lines;
    lines = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin errors++; $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp_vec); end
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 5) == 0) lines[b] = ~lines[b];
      {bus.rx_evt_a, bus.ext_irq_a, bus.sft_irq_a, bus.tmr_irq_a, bus.nmi_a, bus.dbg_irq_a} = lines;
      bus.nmi_ack = ($urandom_range(0, 3) == 0);
      bus.dbg_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) bus.core_wfi = ~bus.core_wfi;
      if ($urandom_range(0, 15) == 0) bus.mie_mask = 3'($urandom_range(0, 7));
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_sleep();
    int pulses;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.core_wfi = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (m.st !== 2'd1 || bus.wfi_wake !== 1'b0) begin errors++; $display("FAIL sleep_entry: wake=%b want 0", bus.wfi_wake); end
    bus.nmi_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL sleep_reset: got %h want 0", dut_vec); end
    repeat (3) @(negedge clk);
    bus.core_wfi = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(bus.wfi_wake);
    end
    checks++;
    if (pulses !== 0 || bus.nmi_pend !== 1'b0 || bus.evt_cnt !== '0)
      begin errors++; $display("FAIL post_reset_quiet: pulses=%0d pend=%b cnt=%0d want 0 0 0", pulses, bus.nmi_pend, bus.evt_cnt); end
    bus.nmi_a = 1'b0;
    repeat (2) @(negedge clk);
    bus.nmi_a = 1'b1;
    repeat (D + 1) @(negedge clk);
    checks++;
    if (bus.nmi_pend !== 1'b1 || bus.evt_cnt !== 8'd1)
      begin errors++; $display("FAIL retoggle_pend: pend=%b cnt=%0d want 1 1", bus.nmi_pend, bus.evt_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_nmi_latency();
    test_ack_collision();
    test_wfi_wake();
    test_rx_evt();
    test_saturation();
    test_random();
    test_reset_in_sleep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/n100_irq_sync.md
N100_IRQ_SYNC -- requirements
Module: n100_irq_sync

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the saturating event counter.
REQ-002 SHALL have port clk  input  1  core clock; all state rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports dbg_irq_a, nmi_a, tmr_irq_a, sft_irq_a, ext_irq_a, rx_evt_a  input  1 each  asynchronous interrupt/event lines from the testbench irq generator.
REQ-005 SHALL have port dbg_ack, nmi_ack  input  1 each  core acknowledges pending debug request / NMI.
REQ-006 SHALL have port core_wfi  input  1  core is executing WFI.
REQ-007 SHALL have port mie_mask  input  3  {meie, mtie, msie} enables for wake qualification.
REQ-008 SHALL have ports tmr_irq, sft_irq, ext_irq  output  1 each  synchronized level interrupts.
REQ-009 SHALL have ports dbg_pend, nmi_pend, rx_evt_pend  output  1 each  latched edge events.
REQ-010 SHALL have port wfi_wake  output  1  one-cycle wake pulse.
REQ-011 SHALL have port evt_cnt  output  CNT_W  count of accepted nmi/dbg edges.

Function
REQ-012 SHALL pass every *_a input through a synchronizer (depth per REQ-031/032) before any use.
REQ-013 SHALL drive tmr_irq/sft_irq/ext_irq as the synchronized level, no further latching.
REQ-014 SHALL detect rising edges on synchronized nmi, dbg, rx_evt by comparing against a one-cycle-delayed copy.
REQ-015 SHALL set nmi_pend the cycle after a synchronized nmi rising edge; clear it the cycle after nmi_ack.
REQ-016 SHALL keep nmi_pend set when a new nmi edge and nmi_ack coincide (edge wins); identical rule for dbg_pend/dbg_ack.
REQ-017 SHALL ignore nmi_ack/dbg_ack while the matching pend is clear.
REQ-018 SHALL set rx_evt_pend on an rx_evt rising edge; clear it only in state WAKE (REQ-021).
REQ-019 SHALL implement wake FSM states IDLE, SLEEP, WAKE.
REQ-020 SHALL transition IDLE->SLEEP when core_wfi=1; SLEEP->IDLE when core_wfi=0 with no wake condition.
REQ-021 SHALL transition SLEEP->WAKE when any of nmi_pend, dbg_pend, rx_evt_pend, (ext_irq&meie), (tmr_irq&mtie), (sft_irq&msie) is 1; WAKE asserts wfi_wake for exactly one cycle, clears rx_evt_pend, then ->IDLE.
REQ-022 SHALL give wake precedence over core_wfi deassertion when both occur in SLEEP.
REQ-023 SHALL not re-enter SLEEP from IDLE until core_wfi has been observed 0 for at least one cycle after a WAKE.
REQ-024 SHALL increment evt_cnt by 1 per cycle with an nmi or dbg rising edge (by 2 when both), saturating at all-ones; no wrap.
REQ-025 SHALL keep wfi_wake combinationally equal to (state==WAKE), glitch-free from a register.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously clear all synchronizer flops, edge-history flops, pend flags and evt_cnt, and force FSM to IDLE.
REQ-027 SHALL drive every output 0 during reset and the first cycle after release.
REQ-028 SHALL not report an edge for an input already high at reset release until it falls and rises again.
REQ-029 SHALL abandon SLEEP/WAKE on reset mid-operation with no wfi_wake pulse emitted.
REQ-030 SHALL synchronize rst_n deassertion externally; the block adds no reset synchronizer.

Configuration
REQ-031 With N100_IRQ_SYNC_2FF_EN defined, SHALL use two synchronizer flops per input: input-to-level-output latency 2 cycles, to pend 3 cycles.
REQ-032 Without N100_IRQ_SYNC_2FF_EN, SHALL use one flop per input: latencies 1 and 2 cycles respectively; all other behaviour unchanged.

Verification
REQ-033 Bench SHALL drive nmi_a 0->1 at cycle 10 (2FF on) -> nmi_pend=1 at cycle 13, evt_cnt=1; nmi_ack at cycle 20 -> nmi_pend=0 at cycle 21.
REQ-034 Bench SHALL hold nmi edge and nmi_ack in the same cycle -> nmi_pend stays 1, evt_cnt increments.
REQ-035 Bench SHALL set core_wfi=1, mie_mask=3'b010, raise tmr_irq_a -> exactly one wfi_wake pulse; repeat with mie_mask=0 -> no pulse, FSM stays SLEEP.
REQ-036 Bench SHALL pulse rx_evt_a during SLEEP -> wfi_wake one cycle, rx_evt_pend cleared same transition.
REQ-037 Bench SHALL generate 300 dbg edges with CNT_W=8 -> evt_cnt saturates at 255.
REQ-038 Bench SHALL assert rst_n=0 while FSM in SLEEP with nmi_a high -> all outputs 0; after release no nmi_pend until nmi_a re-toggles.
